encoder_proj: RTL and testbench
===============================

ENCODER_PROJ -- requirements
Module: encoder_proj

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, sets clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, sets nibble FIFO entries; power of two, 2..16.
REQ-003 Port clock, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_data, input, 4 bits: data nibble d[3:0] to encode.
REQ-006 Port in_valid, input, 1 bit: in_data is valid.
REQ-007 Port in_ready, output, 1 bit: FIFO can accept a nibble.
REQ-008 Port io_out, output, 7 bits: Hamming(7,4) codeword of the frame currently being launched; held until the next launch.
REQ-009 Port io_out_valid, output, 1 bit: one-cycle pulse when io_out updates.
REQ-010 Port tx, output, 1 bit: serial line, idle high.
REQ-011 Port tx_busy, output, 1 bit: high while a frame is on tx.
REQ-012 Port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-013 Handshake: a nibble is accepted on a rising edge with in_valid and in_ready both high; in_ready = FIFO not full.
REQ-014 When the FIFO is full, in_ready is low and no push occurs, even if a pop happens in the same cycle.
REQ-015 Codeword bits: c0=p1=d0^d1^d3, c1=p2=d0^d2^d3, c2=d0, c3=p3=d1^d2^d3, c4=d1, c5=d2, c6=d3.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE with FIFO non-empty: pop, register codeword into shift register and io_out, pulse io_out_valid, go to START. tx goes low on the same edge.
REQ-018 Latency: a nibble pushed into an empty FIFO in IDLE at edge N drives tx low from edge N+1.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: c0 first through c6 last (LSB-first), each bit held CLKS_PER_BIT cycles; a 3-bit bit index and an 8-bit baud counter wrap to 0 at each transition.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles. At the end, pop immediately into START if the FIFO is non-empty (no idle gap); otherwise go to IDLE.
REQ-022 A frame is 9*CLKS_PER_BIT cycles; tx_busy is high in START, DATA and STOP.
REQ-023 Push and pop in the same cycle leave fifo_level unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 in_data captured while in_valid is low is ignored; in_valid may drop without acceptance.

Reset
REQ-025 Assertion of rst_n low asynchronously forces: FSM=IDLE, tx=1, tx_busy=0, io_out=0, io_out_valid=0, fifo_level=0, pointers and counters 0, in_ready=1 after release.
REQ-026 Reset mid-frame aborts the frame: tx returns high immediately and FIFO contents are discarded.
REQ-027 Deassertion is synchronised by the integrator upstream; the block samples no input until the first edge after release.

Structure
REQ-028 Shared package encoder_proj_pkg holds the FSM state enum, the Hamming bit-position constants and a hamming74_encode function reused by the decoder side.
REQ-029 One sub-module, encoder_proj_fifo (parameterised sync FIFO with level output), instantiated once; the encoder itself is combinational inside the top.

Verification
REQ-030 Encode table: push 0x0, 0x1, 0xB, 0xF -> io_out = 7'b0000000, 7'b0000111, 7'b1010101, 7'b1111111 on successive io_out_valid pulses.
REQ-031 Serial frame: CLKS_PER_BIT=4, push 0xB -> tx = 0,1,0,1,0,1,0,1,1 with each bit held 4 cycles, 36 cycles total, then idle high.
REQ-032 Back-to-back: push 0x1 and 0xF in consecutive cycles -> the second start bit begins on the cycle after the first stop bit ends; no idle gap.
REQ-033 Full FIFO: with tx stalled mid-frame, push 5 nibbles at depth 4 -> fifo_level=4, in_ready=0, the fifth nibble is not accepted and never appears on tx.
REQ-034 Reset mid-DATA: assert rst_n low at bit 3 -> tx=1, tx_busy=0, fifo_level=0 in the same cycle; a post-reset push of 0x0 yields a clean frame.
REQ-035 Simultaneous push and pop at fifo_level=2 -> fifo_level stays 2, and FIFO order is preserved in the tx output.

Source files
------------

// File: rtl/encoder_proj_pkg.sv
// rtl/encoder_proj_pkg.sv - shared FSM states and Hamming(7,4) encode helper
package encoder_proj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CODE_W = 7;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P3_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [3:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[P1_POS] = d[0] ^ d[1] ^ d[3];
    c[P2_POS] = d[0] ^ d[2] ^ d[3];
    c[D0_POS] = d[0];
    c[P3_POS] = d[1] ^ d[2] ^ d[3];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    return c;
  endfunction

endpackage

// File: rtl/encoder_proj_fifo.sv
// rtl/encoder_proj_fifo.sv - synchronous FIFO with occupancy output
module encoder_proj_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr,
  output logic                     full,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO refuses the write even when a read frees a slot this cycle
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr && !full;
  assign do_rd   = rd && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/encoder_proj.sv
// rtl/encoder_proj.sv - nibble FIFO, Hamming(7,4) encoder and serial framer
module encoder_proj
  import encoder_proj_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [3:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CODE_W-1:0]             io_out,
  output logic                          io_out_valid,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  state_t            state;
  state_t            state_next;
  logic [7:0]        baud;
  logic [2:0]        bit_idx;
  logic [CODE_W-1:0] shreg;
  logic [CODE_W-1:0] code;
  logic [3:0]        fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              bit_done;

  encoder_proj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .wr_data (in_data),
    .wr      (in_valid),
    .full    (fifo_full),
    .rd      (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign bit_done = (baud == BAUD_LAST);
  assign code     = hamming74_encode(fifo_data);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Launch happens from IDLE or straight out of STOP, so frames chain with no gap
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_done) state_next = DATA;
      DATA:  if (bit_done && bit_idx == 3'd6) state_next = STOP;
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      baud         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      io_out       <= '0;
      io_out_valid <= 1'b0;
    end else begin
      io_out_valid <= pop;
      if (pop) begin
        shreg  <= code;
        io_out <= code;
      end else if (state == DATA && bit_done) begin
        shreg <= {1'b0, shreg[CODE_W-1:1]};
      end
      if (state == IDLE || bit_done) baud <= '0;
      else                           baud <= baud + 8'd1;
      if (state == DATA && bit_done)
        bit_idx <= (bit_idx == 3'd6) ? 3'd0 : bit_idx + 3'd1;
    end
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = 1'b1;
    case (state)
      IDLE:    tx_busy = 1'b0;
      START:   tx      = 1'b0;
      DATA:    tx      = shreg[0];
      STOP:    tx      = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_encoder_proj.sv
// tb/tb_encoder_proj.sv - directed bench for encoder_proj
module tb_encoder_proj;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] io_out;
  logic       io_out_valid;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_level;

  encoder_proj #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .io_out       (io_out),
    .io_out_valid (io_out_valid),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .fifo_level   (fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] code;
  } vec_t;

  vec_t       tbl [6];
  logic [6:0] exp_q [$];
  logic [6:0] got_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Entered at the first negedge after a launch edge; checks every cycle of each frame
  task automatic check_frames(input string name);
    logic [6:0] cw;
    logic       ok;
    logic       e;
    for (int f = 0; f < exp_q.size(); f++) begin
      cw = exp_q[f];
      for (int b = 0; b < 9; b++) begin
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
          e = (b == 0) ? 1'b0 : (b == 8) ? 1'b1 : cw[b-1];
          if (tx !== e || tx_busy !== 1'b1) ok = 1'b0;
          if (b == 0 && c == 0) begin
            chk($sformatf("%s f%0d io_out_valid", name, f), 32'(io_out_valid), 32'd1);
            chk($sformatf("%s f%0d io_out", name, f), 32'(io_out), 32'(cw));
          end else if (io_out_valid !== 1'b0) begin
            ok = 1'b0;
          end
          @(negedge clock);
        end
        chk($sformatf("%s f%0d bit%0d", name, f, b), 32'(ok), 32'd1);
      end
    end
    chk($sformatf("%s idle tx", name), 32'(tx), 32'd1);
    chk($sformatf("%s idle tx_busy", name), 32'(tx_busy), 32'd0);
  endtask

  initial begin
    tbl[0] = '{4'h0, 7'h00};
    tbl[1] = '{4'h1, 7'h07};
    tbl[2] = '{4'hB, 7'h55};
    tbl[3] = '{4'hF, 7'h7F};
    tbl[4] = '{4'h6, 7'h33};
    tbl[5] = '{4'h8, 7'h4B};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset tx_busy", 32'(tx_busy), 32'd0);
    chk("reset io_out", 32'(io_out), 32'd0);
    chk("reset io_out_valid", 32'(io_out_valid), 32'd0);
    chk("reset fifo_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Encode table with one-cycle launch latency from an empty FIFO
    for (int i = 0; i < 6; i++) begin
      push1(tbl[i].nib);
      chk($sformatf("enc%0d level", i), 32'(fifo_level), 32'd1);
      chk($sformatf("enc%0d not launched", i), 32'(tx), 32'd1);
      @(negedge clock);
      exp_q = {tbl[i].code};
      check_frames($sformatf("enc%0d", i));
    end

    // Back-to-back: 0x1 then 0xF on consecutive edges
    in_data  = 4'h1;
    in_valid = 1'b1;
    @(negedge clock);
    in_data  = 4'hF;
    @(negedge clock);
    in_valid = 1'b0;
    exp_q = {7'h07, 7'h7F};
    check_frames("b2b");

    // Full FIFO while frame 0x3 holds the line
    push1(4'h3);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      in_data  = 4'(4 + i);
      in_valid = 1'b1;
      if (i == 4) chk("full in_ready before 5th", 32'(in_ready), 32'd0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("full level", 32'(fifo_level), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    got_q = {};
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (io_out_valid === 1'b1) got_q.push_back(io_out);
      @(negedge clock);
    end
    chk("full launches", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("full code0", 32'(got_q[0]), 32'h2A);
      chk("full code1", 32'(got_q[1]), 32'h2D);
      chk("full code2", 32'(got_q[2]), 32'h33);
      chk("full code3", 32'(got_q[3]), 32'h34);
    end
    chk("full drained level", 32'(fifo_level), 32'd0);
    chk("full drained tx", 32'(tx), 32'd1);

    // Push coinciding with the STOP-end pop at level 2
    push1(4'h9);
    @(negedge clock);
    push1(4'h2);
    push1(4'h5);
    chk("pushpop level before", 32'(fifo_level), 32'd2);
    repeat (33) @(negedge clock);
    chk("pushpop level at edge", 32'(fifo_level), 32'd2);
    in_data  = 4'hC;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("pushpop level after", 32'(fifo_level), 32'd2);
    exp_q = {7'h19, 7'h2D, 7'h61};
    check_frames("pushpop");

    // Reset during data bit 3 of frame 0x1 with 0x5 queued
    push1(4'h1);
    @(negedge clock);
    push1(4'h5);
    repeat (16) @(negedge clock);
    chk("rst pre tx", 32'(tx), 32'd0);
    chk("rst pre tx_busy", 32'(tx_busy), 32'd1);
    chk("rst pre level", 32'(fifo_level), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst tx_busy", 32'(tx_busy), 32'd0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("rst io_out", 32'(io_out), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst stays idle", 32'(tx_busy), 32'd0);
    push1(4'h0);
    @(negedge clock);
    exp_q = {7'h00};
    check_frames("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
